pll_reset_seq: RTL and testbench

PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

---
 rtl/pll_reset_seq.sv | 152 +++++++++++++++
 tb/tb_pll_reset_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_seq.sv
// rtl/pll_reset_seq.sv - PLL reset / lock-qualification sequencer producing a registered system reset.
module pll_reset_seq #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_STABLE    = 2700,
    parameter int unsigned HOLD_CYCLES    = 270,
    parameter int unsigned LOCK_TIMEOUT   = 2700000
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       lock,
    input  logic       soft_reset,
    output logic       pll_reset,
    output logic       rst_out,
    output logic       ready,
    output logic [3:0] retry_cnt
);

    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    localparam logic [23:0] PLL_RST_LAST = 24'(PLL_RST_CYCLES - 1);
    localparam logic [23:0] STABLE_LAST  = 24'(LOCK_STABLE - 1);
    localparam logic [23:0] TIMEOUT_LAST = 24'(LOCK_TIMEOUT - 1);
    // HOLD counts its entry edge separately, so the terminal value is HOLD_CYCLES itself.
    localparam logic [23:0] HOLD_LAST    = 24'(HOLD_CYCLES);
    localparam logic [3:0]  RETRY_MAX    = 4'd15;

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [23:0] tmo_q, tmo_d;
    logic [3:0]  retry_q, retry_d;
    logic        lock_meta_q, lock_s_q;
    logic        pll_reset_q, pll_reset_d;
    logic        rst_out_q, rst_out_d;
    logic        ready_q, ready_d;
    logic        retry_bump;

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        retry_bump = 1'b0;
        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == PLL_RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                    tmo_d   = '0;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            ST_WAIT_LOCK: begin
                tmo_d = tmo_q + 24'd1;
                cnt_d = lock_s_q ? (cnt_q + 24'd1) : '0;
                // Lock acceptance is checked first so it wins a tie with the timeout.
                if (lock_s_q && (cnt_q == STABLE_LAST)) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    tmo_d   = '0;
                end else if (tmo_q == TIMEOUT_LAST) begin
                    state_d    = ST_PLL_RST;
                    cnt_d      = '0;
                    tmo_d      = '0;
                    retry_bump = 1'b1;
                end
            end
            ST_HOLD: begin
                tmo_d = '0;
                if (!lock_s_q) begin
                    state_d    = ST_PLL_RST;
                    cnt_d      = '0;
                    retry_bump = 1'b1;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            ST_RUN: begin
                tmo_d = '0;
                cnt_d = '0;
                if (!lock_s_q) begin
                    state_d    = ST_PLL_RST;
                    retry_bump = 1'b1;
                end else if (soft_reset) begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_PLL_RST;
                cnt_d   = '0;
                tmo_d   = '0;
            end
        endcase
    end

    always_comb begin
        retry_d = retry_q;
        if (retry_bump && (retry_q != RETRY_MAX)) begin
            retry_d = retry_q + 4'd1;
        end
    end

    // Outputs are loaded from the next-state decode so they change on the same edge as the state.
    always_comb begin
        pll_reset_d = (state_d == ST_PLL_RST);
        rst_out_d   = (state_d != ST_RUN);
        ready_d     = (state_d == ST_RUN);
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q     <= ST_PLL_RST;
            cnt_q       <= '0;
            tmo_q       <= '0;
            retry_q     <= '0;
            pll_reset_q <= 1'b1;
            rst_out_q   <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            retry_q     <= retry_d;
            pll_reset_q <= pll_reset_d;
            rst_out_q   <= rst_out_d;
            ready_q     <= ready_d;
        end
    end

    assign pll_reset = pll_reset_q;
    assign rst_out   = rst_out_q;
    assign ready     = ready_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb/tb_pll_reset_seq.sv - directed scoreboard bench for pll_reset_seq.
module tb_pll_reset_seq;

    logic       clk;
    logic       reset;
    logic       lock;
    logic       soft_reset;
    logic       pll_reset;
    logic       rst_out;
    logic       ready;
    logic [3:0] retry_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic       pll;
        logic       rst;
        logic       rdy;
        logic [3:0] rc;
    } exp_t;

    exp_t sb[$];

    pll_reset_seq #(
        .PLL_RST_CYCLES(4),
        .LOCK_STABLE   (8),
        .HOLD_CYCLES   (16),
        .LOCK_TIMEOUT  (64)
    ) dut (
        .clkin     (clk),
        .reset     (reset),
        .lock      (lock),
        .soft_reset(soft_reset),
        .pll_reset (pll_reset),
        .rst_out   (rst_out),
        .ready     (ready),
        .retry_cnt (retry_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input string tag, input logic pll, input logic rst,
                            input logic rdy, input logic [3:0] rc);
        exp_t e;
        e.tag = tag;
        e.pll = pll;
        e.rst = rst;
        e.rdy = rdy;
        e.rc  = rc;
        sb.push_back(e);
    endtask

    task automatic exp_check();
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard_empty got 0 entries want 1");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            assert (pll_reset === e.pll) else begin
                errors++;
                $error("FAIL %s.pll_reset got %0b want %0b", e.tag, pll_reset, e.pll);
            end
            checks++;
            assert (rst_out === e.rst) else begin
                errors++;
                $error("FAIL %s.rst_out got %0b want %0b", e.tag, rst_out, e.rst);
            end
            checks++;
            assert (ready === e.rdy) else begin
                errors++;
                $error("FAIL %s.ready got %0b want %0b", e.tag, ready, e.rdy);
            end
            checks++;
            assert (retry_cnt === e.rc) else begin
                errors++;
                $error("FAIL %s.retry_cnt got %0d want %0d", e.tag, retry_cnt, e.rc);
            end
        end
    endtask

    initial begin
        int rc_exp;
        reset      = 1'b1;
        lock       = 1'b0;
        soft_reset = 1'b0;
        #22;
        exp_push("in_reset", 1'b1, 1'b1, 1'b0, 4'd0);
        exp_check();

        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_push("start_e3", 1'b1, 1'b1, 1'b0, 4'd0);
        tick(3);
        exp_check();
        exp_push("start_e4", 1'b0, 1'b1, 1'b0, 4'd0);
        tick(1);
        exp_check();
        tick(1);
        lock = 1'b1;
        exp_push("start_e31", 1'b0, 1'b1, 1'b0, 4'd0);
        tick(26);
        exp_check();
        exp_push("start_e32", 1'b0, 1'b0, 1'b1, 4'd0);
        tick(1);
        exp_check();

        // Soft reset: one-cycle pulse, rst_out high for 17 edges.
        tick(3);
        soft_reset = 1'b1;
        exp_push("soft_entry", 1'b0, 1'b1, 1'b0, 4'd0);
        tick(1);
        soft_reset = 1'b0;
        exp_check();
        exp_push("soft_e16", 1'b0, 1'b1, 1'b0, 4'd0);
        tick(16);
        exp_check();
        exp_push("soft_e17", 1'b0, 1'b0, 1'b1, 4'd0);
        tick(1);
        exp_check();

        tick(2);
        lock = 1'b0;
        exp_push("drop_e2", 1'b0, 1'b0, 1'b1, 4'd0);
        tick(2);
        exp_check();
        exp_push("drop_e3", 1'b1, 1'b1, 1'b0, 4'd1);
        tick(1);
        exp_check();
        lock = 1'b1;
        exp_push("resq_e6", 1'b1, 1'b1, 1'b0, 4'd1);
        tick(3);
        exp_check();
        exp_push("resq_e7", 1'b0, 1'b1, 1'b0, 4'd1);
        tick(1);
        exp_check();
        exp_push("resq_e31", 1'b0, 1'b1, 1'b0, 4'd1);
        tick(24);
        exp_check();
        exp_push("resq_e32", 1'b0, 1'b0, 1'b1, 4'd1);
        tick(1);
        exp_check();

        // Lock loss and soft reset seen in the same FSM cycle.
        tick(2);
        lock = 1'b0;
        exp_push("both_e2", 1'b0, 1'b0, 1'b1, 4'd1);
        tick(2);
        exp_check();
        soft_reset = 1'b1;
        exp_push("both_e3", 1'b1, 1'b1, 1'b0, 4'd2);
        tick(1);
        soft_reset = 1'b0;
        exp_check();

        exp_push("tmo_first_wait", 1'b0, 1'b1, 1'b0, 4'd2);
        tick(4);
        exp_check();
        exp_push("tmo_first_e67", 1'b0, 1'b1, 1'b0, 4'd2);
        tick(63);
        exp_check();
        exp_push("tmo_first_e68", 1'b1, 1'b1, 1'b0, 4'd3);
        tick(1);
        exp_check();
        for (int k = 4; k <= 17; k++) begin
            rc_exp = (k - 1 > 15) ? 15 : (k - 1);
            exp_push("tmo_wait", 1'b0, 1'b1, 1'b0, 4'(rc_exp));
            tick(4);
            exp_check();
            rc_exp = (k > 15) ? 15 : k;
            exp_push("tmo_retry", 1'b1, 1'b1, 1'b0, 4'(rc_exp));
            tick(64);
            exp_check();
        end

        // Glitchy lock: 5 high, 1 low, then steady.
        tick(4);
        lock = 1'b1;
        tick(5);
        lock = 1'b0;
        tick(1);
        lock = 1'b1;
        exp_push("glitch_e36", 1'b0, 1'b1, 1'b0, 4'd15);
        tick(26);
        exp_check();
        exp_push("glitch_e37", 1'b0, 1'b0, 1'b1, 4'd15);
        tick(1);
        exp_check();

        // Asynchronous reset while in HOLD.
        tick(2);
        soft_reset = 1'b1;
        tick(1);
        soft_reset = 1'b0;
        tick(3);
        #3;
        reset = 1'b1;
        #1;
        exp_push("async_rst", 1'b1, 1'b1, 1'b0, 4'd0);
        exp_check();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Lock loss during HOLD after restart.
        tick(13);
        lock = 1'b0;
        exp_push("hold_drop_e15", 1'b0, 1'b1, 1'b0, 4'd0);
        tick(2);
        exp_check();
        exp_push("hold_drop_e16", 1'b1, 1'b1, 1'b0, 4'd1);
        tick(1);
        exp_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
